// File: rtl/uart_mem_ctrl_pkg.sv
// uart_mem_pkg: shared state encoding and command bytes for uart_mem_ctrl
package uart_mem_pkg;
    typedef enum logic [3:0] {
        IDLE, W_AH, W_AL, W_DH, W_DL, WRITE, ACK,
        R_AH, R_AL, READ, SEND_HI, WAIT_HI, SEND_LO, WAIT_TX_LAST
    } state_t;
    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h4B;
endpackage

// File: rtl/uart_mem_ctrl_if.sv
// uart_mem_ctrl_if: UART byte stream plus block-memory port A bundle
interface uart_mem_ctrl_if #(parameter int ADDR_W = 15, parameter int DATA_W = 16);
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              tx_done;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              wea;
    logic [DATA_W-1:0] douta;
    logic              busy;
    logic              err;
    logic [15:0]       wr_count;
    modport master (
        input  rx_ready, rx_data, tx_done, douta,
        output tx_start, tx_data, addra, dina, wea, busy, err, wr_count
    );
    modport slave (
        output rx_ready, rx_data, tx_done, douta,
        input  tx_start, tx_data, addra, dina, wea, busy, err, wr_count
    );
endinterface

// File: rtl/uart_mem_ctrl_cmd_timeout.sv
// cmd_timeout: inter-byte watchdog, expires after TIMEOUT_CYC cycles without a byte
module cmd_timeout #(parameter int TIMEOUT_CYC = 1000000) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk)
        cnt <= (!reset || clear || !enable || expire) ? '0 : cnt + CW'(1);
    assign expire = enable && cnt == CW'(TIMEOUT_CYC);
endmodule

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: byte-command sequencer driving block-memory port A from the UART pair
module uart_mem_ctrl
    import uart_mem_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic clk,
    input logic reset,
    uart_mem_ctrl_if.master bus
);
    localparam int RW = $clog2(RD_LAT + 2);
    state_t state, state_n;
    logic [RW-1:0] rd_cnt;
    logic [7:0] rd_lo;
    logic collect, expire;
    assign collect = state inside {W_AH, W_AL, W_DH, W_DL, R_AH, R_AL};
    cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk(clk), .reset(reset), .clear(bus.rx_ready), .enable(collect), .expire(expire)
    );
    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:         state_n = !bus.rx_ready ? IDLE : bus.rx_data == CMD_WR ? W_AH :
                                    bus.rx_data == CMD_RD ? R_AH : IDLE;
            W_AH:         state_n = bus.rx_ready ? W_AL  : expire ? IDLE : W_AH;
            W_AL:         state_n = bus.rx_ready ? W_DH  : expire ? IDLE : W_AL;
            W_DH:         state_n = bus.rx_ready ? W_DL  : expire ? IDLE : W_DH;
            W_DL:         state_n = bus.rx_ready ? WRITE : expire ? IDLE : W_DL;
            WRITE:        state_n = ACK;
            ACK:          state_n = WAIT_TX_LAST;
            R_AH:         state_n = bus.rx_ready ? R_AL  : expire ? IDLE : R_AH;
            R_AL:         state_n = bus.rx_ready ? READ  : expire ? IDLE : R_AL;
            READ:         state_n = rd_cnt == RW'(RD_LAT) ? SEND_HI : READ;
            SEND_HI:      state_n = WAIT_HI;
            WAIT_HI:      state_n = bus.tx_done ? SEND_LO : WAIT_HI;
            SEND_LO:      state_n = WAIT_TX_LAST;
            WAIT_TX_LAST: state_n = bus.tx_done ? IDLE : WAIT_TX_LAST;
            default:      state_n = IDLE;
        endcase
    end
    always_comb begin
        bus.wea      = state == WRITE;
        bus.tx_start = state inside {ACK, SEND_HI, SEND_LO};
        bus.busy     = state != IDLE;
        bus.err      = reset && (bus.rx_ready
                       ? (state == IDLE ? bus.rx_data != CMD_WR && bus.rx_data != CMD_RD : !collect)
                       : expire);
    end
    // READ lasts RD_LAT+1 cycles so douta is sampled on the cycle it first becomes valid
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.addra    <= '0;
            bus.dina     <= '0;
            bus.tx_data  <= '0;
            bus.wr_count <= '0;
            rd_cnt       <= '0;
            rd_lo        <= '0;
        end else begin
            rd_cnt <= state == READ ? rd_cnt + RW'(1) : '0;
            if (bus.rx_ready && state inside {W_AH, R_AH}) bus.addra[ADDR_W-1:8] <= bus.rx_data[ADDR_W-9:0];
            if (bus.rx_ready && state inside {W_AL, R_AL}) bus.addra[7:0] <= bus.rx_data;
            if (bus.rx_ready && state == W_DH) bus.dina[DATA_W-1:8] <= bus.rx_data;
            if (bus.rx_ready && state == W_DL) bus.dina[7:0] <= bus.rx_data;
            if (state == WRITE) bus.wr_count <= bus.wr_count + 16'd1;
            if (state_n == SEND_HI) rd_lo <= bus.douta[7:0];
            bus.tx_data <= state_n == ACK ? ACK_BYTE : state_n == SEND_HI ? bus.douta[DATA_W-1:8] :
                           state_n == SEND_LO ? rd_lo : bus.tx_data;
        end
    end
endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: directed checks of the UART memory command sequencer
module tb_uart_mem_ctrl;
    logic clk = 0;
    logic reset = 0;
    int total = 0, bad = 0, cyc = 0;
    int wea_n = 0, err_n = 0, busy_n = 0, last_rx = 0, wea_lat = 0, tx_lat = 0;
    int tx_early = 0, tx_unstable = 0;
    logic got_tx = 0;
    logic [14:0] wea_addr = '0;
    logic [15:0] wea_din = '0;
    logic [7:0] tx_q[$];
    logic [15:0] mem [0:32767];
    uart_mem_ctrl_if #(.ADDR_W(15), .DATA_W(16)) bus();
    uart_mem_ctrl #(.ADDR_W(15), .DATA_W(16), .RD_LAT(1), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        if (bus.wea) mem[bus.addra] <= bus.dina;
        bus.douta <= mem[bus.addra];
    end
    always @(negedge clk) begin
        if (bus.rx_ready) begin last_rx = cyc; got_tx = 0; end
        if (bus.wea) begin wea_n++; wea_addr = bus.addra; wea_din = bus.dina; wea_lat = cyc - last_rx; end
        if (bus.tx_start && !got_tx) begin tx_lat = cyc - last_rx; got_tx = 1; end
        if (bus.err) err_n++;
        if (bus.busy) busy_n++;
    end
    initial begin
        bus.tx_done = 0;
        forever begin
            @(negedge clk);
            bus.tx_done = 0;
            if (bus.tx_start) begin
                tx_q.push_back(bus.tx_data);
                repeat (4) begin
                    @(negedge clk);
                    if (bus.tx_start) tx_early++;
                    if (bus.tx_data != tx_q[$]) tx_unstable++;
                end
                bus.tx_done = 1;
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] pop();
        if (tx_q.size() == 0) return 32'hDEAD;
        return {24'h0, tx_q.pop_front()};
    endfunction
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1 bus.rx_data = b; bus.rx_ready = 1;
        @(posedge clk); #1 bus.rx_ready = 0;
    endtask
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        send(8'h57); send(a[15:8]); send(a[7:0]); send(d[15:8]); send(d[7:0]);
    endtask
    task automatic rd(input logic [15:0] a);
        send(8'h52); send(a[15:8]); send(a[7:0]);
    endtask
    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy && n < 300) begin @(negedge clk); n++; end
        chk(tag, {31'h0, bus.busy}, 0);
    endtask
    initial begin
        int e0, w0, b0, n;
        bus.rx_ready = 0;
        bus.rx_data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_addra", bus.addra, 0);
        chk("rst_wrc", bus.wr_count, 0);
        chk("rst_txd", bus.tx_data, 0);
        reset = 1;
        wr(16'h0001, 16'hAAAA);
        wait_idle("w1_idle");
        chk("w1_wea_n", wea_n, 1);
        chk("w1_addr", wea_addr, 15'h0001);
        chk("w1_din", wea_din, 16'hAAAA);
        chk("w1_lat", wea_lat, 1);
        chk("w1_ack", pop(), 8'h4B);
        chk("w1_wrc", bus.wr_count, 1);
        wr(16'h0002, 16'h5555);
        wait_idle("w2_idle");
        chk("w2_ack", pop(), 8'h4B);
        rd(16'h0002);
        wait_idle("r2_idle");
        chk("r2_hi", pop(), 8'h55);
        chk("r2_lo", pop(), 8'h55);
        chk("r2_lat", tx_lat, 3);
        wr(16'h0005, 16'h1234);
        wait_idle("w5_idle");
        chk("w5_ack", pop(), 8'h4B);
        rd(16'h0005);
        wait_idle("r5_idle");
        chk("r5_hi", pop(), 8'h12);
        chk("r5_lo", pop(), 8'h34);
        wr(16'hFFFF, 16'hCCCC);
        wait_idle("wm_idle");
        chk("wm_addr", wea_addr, 15'h7FFF);
        chk("wm_din", wea_din, 16'hCCCC);
        chk("wm_ack", pop(), 8'h4B);
        chk("wm_wrc", bus.wr_count, 4);
        force bus.wr_count = 16'hFFFF;
        @(posedge clk); #1 release bus.wr_count;
        @(negedge clk);
        chk("wrap_pre", bus.wr_count, 16'hFFFF);
        wr(16'h0006, 16'h0606);
        wait_idle("wrap_idle");
        chk("wrap_wrc", bus.wr_count, 0);
        chk("wrap_ack", pop(), 8'h4B);
        e0 = err_n; b0 = busy_n;
        send(8'h41);
        repeat (3) @(negedge clk);
        chk("op_err", err_n - e0, 1);
        chk("op_busy", busy_n - b0, 0);
        e0 = err_n; w0 = wea_n; n = 0;
        send(8'h57); send(8'h00);
        do begin @(negedge clk); n++; end while (!bus.err && n < 200);
        chk("to_cyc", n, 51);
        wait_idle("to_idle");
        chk("to_err", err_n - e0, 1);
        chk("to_wea", wea_n - w0, 0);
        e0 = err_n; n = 0;
        rd(16'h0005);
        while (tx_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
        send(8'h33);
        wait_idle("or_idle");
        chk("or_err", err_n - e0, 1);
        chk("or_hi", pop(), 8'h12);
        chk("or_lo", pop(), 8'h34);
        w0 = wea_n;
        send(8'h57); send(8'h00); send(8'h03); send(8'h33);
        reset = 0;
        @(posedge clk); #1;
        chk("mr_busy", bus.busy, 0);
        chk("mr_addra", bus.addra, 0);
        chk("mr_dina", bus.dina, 0);
        chk("mr_wrc", bus.wr_count, 0);
        chk("mr_txd", bus.tx_data, 0);
        reset = 1;
        chk("mr_wea", wea_n - w0, 0);
        wr(16'h0004, 16'h3333);
        wait_idle("mr2_idle");
        chk("mr2_addr", wea_addr, 15'h0004);
        chk("mr2_din", wea_din, 16'h3333);
        chk("mr2_wrc", bus.wr_count, 1);
        chk("mr2_ack", pop(), 8'h4B);
        chk("mr2_mem", mem[4], 16'h3333);
        chk("tx_early", tx_early, 0);
        chk("tx_stable", tx_unstable, 0);
        chk("tx_left", tx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_mem_ctrl.md
Name: uart_mem_ctrl

Overview:
- Command sequencer between the UART receiver/transmitter pair and the 16-bit-wide block memory (port A) inside core.
- Parses byte commands from RX to write or read one 16-bit memory word.
- Returns read data or a write acknowledge through TX.
- Replaces bench-level direct poking of addra/dina/wea with a real on-chip path.

Parameters:
- ADDR_W, 15, memory address width; addra width.
- DATA_W, 16, memory word width; fixed at two bytes.
- RD_LAT, 1, clock cycles from addra valid to douta valid.
- TIMEOUT_CYC, 1000000, maximum idle cycles between bytes of one command before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- rx_ready  in  1  one-cycle pulse: rx_data holds a new received byte.
- rx_data  in  8  received byte.
- tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- tx_start  out  1  one-cycle pulse: load tx_data into the transmitter.
- tx_data  out  8  byte to transmit; stable from tx_start until tx_done.
- addra  out  ADDR_W  memory address.
- dina  out  DATA_W  memory write data.
- wea  out  1  memory write enable, one cycle per write.
- douta  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  one-cycle pulse on protocol error: bad opcode, timeout or overrun.
- wr_count  out  16  number of completed writes, wraps at 0xFFFF to 0.

Behaviour:
- Reset is synchronous and active-low: reset=0 sampled at a clk rising edge.
  - State goes to IDLE.
  - tx_start, wea, err and busy go to 0.
  - tx_data, addra, dina and wr_count go to 0.
  - The timeout counter goes to 0.
  - Reset mid-command discards the partial command; no write is issued.
- Write command: bytes 0x57 ('W'), AH, AL, DH, DL.
  - Address is {AH[6:0], AL}; AH[7] is ignored.
  - Data is {DH, DL}.
- Read command: bytes 0x52 ('R'), AH, AL.
- States:
  - IDLE:
    - rx_ready with 'W' goes to W_AH.
    - rx_ready with 'R' goes to R_AH.
    - rx_ready with any other byte: pulse err, stay in IDLE.
  - W_AH -> W_AL -> W_DH -> W_DL: each advances on rx_ready and captures the byte.
  - WRITE, entered the cycle after DL is captured:
    - Asserts wea=1 for exactly one cycle with addra/dina valid.
    - Increments wr_count.
    - Goes to ACK.
  - ACK: tx_data=0x4B ('K'), pulse tx_start, go to WAIT_TX_LAST.
  - R_AH -> R_AL: each advances on rx_ready.
  - READ:
    - addra is driven from the cycle after AL is captured.
    - Waits RD_LAT cycles with wea=0.
    - Captures douta into an internal 16-bit register.
    - Goes to SEND_HI.
  - SEND_HI: tx_data = high byte, pulse tx_start, go to WAIT_HI.
  - WAIT_HI: on tx_done, go to SEND_LO.
  - SEND_LO: tx_data = low byte, pulse tx_start, go to WAIT_TX_LAST.
  - WAIT_TX_LAST: on tx_done, go to IDLE.
- Timeout:
  - In any W_*/R_* byte-collection state, a counter increments each cycle without rx_ready.
  - The counter clears on rx_ready.
  - When the counter reaches TIMEOUT_CYC: pulse err, go to IDLE, no memory access.
- Overrun: rx_ready in WRITE, ACK, READ, SEND_* or WAIT_* states:
  - The byte is dropped and err pulses.
  - The current operation continues unaffected.
- Timing:
  - wea is never asserted outside WRITE.
  - addra/dina hold their last values when idle.
- Latency:
  - Write: the wea pulse occurs 1 cycle after the DL rx_ready.
  - Read: the first tx_start occurs RD_LAT+2 cycles after the AL rx_ready.
- Simultaneous tx_done and rx_ready in WAIT_TX_LAST:
  - The state returns to IDLE.
  - The rx byte counts as overrun (err) and is not parsed.
- tx_done in a state not waiting for it is ignored.

Decomposition:
- Shared package uart_mem_pkg holds:
  - State encoding constants.
  - Opcode constants CMD_WR=8'h57, CMD_RD=8'h52, ACK_BYTE=8'h4B.
- One natural sub-module: cmd_timeout, the inter-byte watchdog counter.
  - Inputs: clear, enable.
  - Output: expire.
  - Parameter: TIMEOUT_CYC.
- The FSM stays in uart_mem_ctrl.

Test Plan:
- Write: after reset, send 57,00,01,AA,AA -> one wea pulse with addra=0x0001, dina=0xAAAA; then tx_start with tx_data=0x4B; wr_count=1.
- Readback: write 0x5555 to 0x0002, then send 52,00,02 (behavioural BRAM, RD_LAT=1) -> tx bytes 0x55 then 0x55, each issued only after the prior tx_done.
- Address masking and wrap:
  - Send 57,FF,FF,CC,CC -> addra=0x7FFF, dina=0xCCCC.
  - Preload wr_count=0xFFFF via 65535 prior writes (or force) -> count wraps to 0.
- Errors:
  - Byte 0x41 in IDLE -> err pulse, busy stays 0.
  - Send 57,00 then idle TIMEOUT_CYC (set to 50) cycles -> err pulse, state IDLE, no wea.
- Overrun: send 0x33 during WAIT_HI of a read -> err pulse, both data bytes still transmitted correctly.
- Reset mid-command: assert reset=0 after 57,00,03,33 -> all outputs return to 0, no wea; a following full write to 0x0004 with 0x3333 succeeds.
